// File: rtl/dcache_ctrl_pkg.sv
// Shared types and constants for the direct-mapped data-cache controller.
// Address split: offset [4:0], index [9:5], tag [31:10].
package dcache_ctrl_pkg;

  localparam int OFFSET_W   = 5;
  localparam int INDEX_W    = 5;
  localparam int TAG_W      = 22;
  localparam int WORD_SEL_W = 3;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    MISS        = 3'd1,
    WRITEBACK   = 3'd2,
    REFILL      = 3'd3,
    REFILL_DONE = 3'd4
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag and data storage for the data cache: one synchronous write port and a
// combinational read port sharing a single index. Reset clears only the valid
// and dirty bits; tags and line data keep their contents.
module dcache_sram
  import dcache_ctrl_pkg::*;
#(
  parameter int LINES  = 32,
  parameter int LINE_W = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] idx_i,
  input  tag_entry_t         entry_i,
  input  logic [LINE_W-1:0]  line_i,
  output tag_entry_t         entry_o,
  output logic [LINE_W-1:0]  line_o
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] line_q [LINES];

  // Status bits: cleared by reset, updated by the write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= entry_i.valid;
      dirty_q[idx_i] <= entry_i.dirty;
    end
  end

  // Tag and data arrays: plain storage, never cleared.
  always_ff @(posedge clk_i) begin
    if (we_i && !rst_i) begin
      tag_q[idx_i]  <= entry_i.tag;
      line_q[idx_i] <= line_i;
    end
  end

  assign entry_o = '{valid: valid_q[idx_i], dirty: dirty_q[idx_i], tag: tag_q[idx_i]};
  assign line_o  = line_q[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller.
// Optional hit/miss statistics are built when DCACHE_STATS_EN is defined.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | serve hits; detect a miss on the current request
// MISS        | decide between write-back of a dirty victim or direct refill
// WRITEBACK   | write the victim line to memory, wait for ack
// REFILL      | fetch the requested line from memory, wait for ack
// REFILL_DONE | one settle cycle; request then re-evaluates as a hit in IDLE
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int LINES  = 32,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);

  state_e                  state_q, state_d;
  logic [INDEX_W-1:0]      req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic [WORD_SEL_W-1:0]   word_sel;
  tag_entry_t              rd_entry, wr_entry;
  logic [LINE_W-1:0]       rd_line, wr_line, store_line;
  logic                    sram_we;
  logic                    hit;
  logic                    unused_addr_bits;

  // The pipeline is frozen while stalled, so the live CPU address stays valid
  // for the whole miss sequence and needs no capture register.
  assign req_idx  = cpu_addr_i[OFFSET_W +: INDEX_W];
  assign req_tag  = cpu_addr_i[OFFSET_W+INDEX_W +: TAG_W];
  assign word_sel = cpu_addr_i[2 +: WORD_SEL_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit = cpu_req_i && rd_entry.valid && (rd_entry.tag == req_tag);

  dcache_sram #(.LINES(LINES), .LINE_W(LINE_W)) u_sram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (sram_we),
    .idx_i   (req_idx),
    .entry_i (wr_entry),
    .line_i  (wr_line),
    .entry_o (rd_entry),
    .line_o  (rd_line)
  );

  // Merge the store word into the currently addressed line.
  always_comb begin
    store_line = rd_line;
    store_line[word_sel*32 +: 32] = cpu_data_i;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; mem_ack_i only matters while a transfer is outstanding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (cpu_req_i && !hit) state_d = MISS;
      MISS:        state_d = (rd_entry.valid && rd_entry.dirty) ? WRITEBACK : REFILL;
      WRITEBACK:   if (mem_ack_i) state_d = REFILL;
      REFILL:      if (mem_ack_i) state_d = REFILL_DONE;
      REFILL_DONE: state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Outputs and array write controls; everything is held at zero during reset.
  always_comb begin
    cpu_data_o   = '0;
    cpu_stall_o  = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    sram_we      = 1'b0;
    wr_entry     = '0;
    wr_line      = rd_line;
    if (!rst_i) begin
      cpu_data_o  = rd_line[word_sel*32 +: 32];
      cpu_stall_o = cpu_req_i && !((state_q == IDLE) && hit);
      case (state_q)
        IDLE: begin
          if (hit && cpu_we_i) begin
            sram_we  = 1'b1;
            wr_entry = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
            wr_line  = store_line;
          end
        end
        WRITEBACK: begin
          mem_enable_o = 1'b1;
          mem_write_o  = 1'b1;
          mem_addr_o   = {rd_entry.tag, req_idx, {OFFSET_W{1'b0}}};
          mem_data_o   = rd_line;
        end
        REFILL: begin
          mem_enable_o = 1'b1;
          mem_addr_o   = {req_tag, req_idx, {OFFSET_W{1'b0}}};
          if (mem_ack_i) begin
            sram_we  = 1'b1;
            wr_entry = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
            wr_line  = mem_data_i;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic        post_refill_q;

  // Hit/miss statistics; the hit that closes a refill is not a real hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      post_refill_q <= 1'b0;
    end else begin
      post_refill_q <= (state_q == REFILL_DONE);
      if ((state_q == IDLE) && hit && !post_refill_q) hit_cnt <= hit_cnt + 32'd1;
      if ((state_q == IDLE) && (state_d == MISS))     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random
// accesses, checked cycle by cycle against a behavioural cache/memory model.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o;
  logic [255:0] mem_data_i, mem_data_o;
  logic         mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o, mem_write_o;

  always #5 clk_i = ~clk_i;

  dcache_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_data_i   (cpu_data_i),
    .cpu_data_o   (cpu_data_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i),
    .mem_data_o   (mem_data_o),
    .mem_addr_o   (mem_addr_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cache contents and a sparse backing memory.
  logic         valid_m [32];
  logic         dirty_m [32];
  logic [21:0]  tag_m   [32];
  logic [255:0] line_m  [32];
  logic [255:0] mem_m   [logic [31:0]];
  int           hits_m, misses_m;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mem_fetch(input logic [31:0] a);
    logic [255:0] l;
    if (mem_m.exists(a)) return mem_m[a];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = a + 32'(w) * 32'h0101_0000 + 32'h0BAD_0001;
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = $urandom();
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      valid_m[i] = 1'b0;
      dirty_m[i] = 1'b0;
    end
    hits_m   = 0;
    misses_m = 0;
  endtask

  task automatic chk_stats();
`ifdef DCACHE_STATS_EN
    chk("hit_cnt",  256'(dut.hit_cnt),  256'(hits_m));
    chk("miss_cnt", 256'(dut.miss_cnt), 256'(misses_m));
`endif
  endtask

  // One cycle with no request: no stall, no memory traffic.
  task automatic idle_cycle();
    cpu_req_i  = 1'b0;
    cpu_we_i   = 1'($urandom_range(0, 1));
    cpu_addr_i = $urandom() & 32'hFFFF_FFFC;
    @(negedge clk_i);
    chk("idle_stall", 256'(cpu_stall_o), 256'd0);
    chk("idle_men",   256'(mem_enable_o), 256'd0);
    @(posedge clk_i); #1;
  endtask

  // Full CPU access; called #1 after a rising edge. dly = extra cycles before ack.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int dly, input bit rst_mid);
    logic [4:0]  idx;
    logic [21:0] tg;
    logic [2:0]  w;
    logic [31:0] vaddr, raddr;
    logic [255:0] fill;
    idx = addr[9:5];
    tg  = addr[31:10];
    w   = addr[4:2];
    cpu_req_i  = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_data_i = wdata;
    @(negedge clk_i);
    if (valid_m[idx] && tag_m[idx] == tg) begin
      chk("hit_stall", 256'(cpu_stall_o), 256'd0);
      chk("hit_men",   256'(mem_enable_o), 256'd0);
      if (!we) chk("hit_rdata", 256'(cpu_data_o), 256'(line_m[idx][w*32 +: 32]));
      hits_m++;
      if (we) begin
        line_m[idx][w*32 +: 32] = wdata;
        dirty_m[idx] = 1'b1;
      end
      @(posedge clk_i); #1;
      cpu_req_i = 1'b0;
      return;
    end
    misses_m++;
    chk("miss_stall", 256'(cpu_stall_o), 256'd1);
    chk("miss_men",   256'(mem_enable_o), 256'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("mst_stall", 256'(cpu_stall_o), 256'd1);
    chk("mst_men",   256'(mem_enable_o), 256'd0);
    mem_ack_i = 1'($urandom_range(0, 1));
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    if (valid_m[idx] && dirty_m[idx]) begin
      vaddr = {tag_m[idx], idx, 5'b0};
      for (int c = 0; c <= dly; c++) begin
        @(negedge clk_i);
        chk("wb_men",   256'(mem_enable_o), 256'd1);
        chk("wb_mwe",   256'(mem_write_o),  256'd1);
        chk("wb_addr",  256'(mem_addr_o),   256'(vaddr));
        chk("wb_data",  mem_data_o,         line_m[idx]);
        chk("wb_stall", 256'(cpu_stall_o),  256'd1);
        mem_ack_i = (c == dly);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
      end
      mem_m[vaddr] = line_m[idx];
    end
    raddr = {tg, idx, 5'b0};
    fill  = mem_fetch(raddr);
    for (int c = 0; c <= dly; c++) begin
      @(negedge clk_i);
      chk("rf_men",   256'(mem_enable_o), 256'd1);
      chk("rf_mwe",   256'(mem_write_o),  256'd0);
      chk("rf_addr",  256'(mem_addr_o),   256'(raddr));
      chk("rf_stall", 256'(cpu_stall_o),  256'd1);
      if (rst_mid) begin
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rst_men",   256'(mem_enable_o), 256'd0);
        chk("rst_mwe",   256'(mem_write_o),  256'd0);
        chk("rst_stall", 256'(cpu_stall_o),  256'd0);
        chk("rst_rdata", 256'(cpu_data_o),   256'd0);
        chk("rst_maddr", 256'(mem_addr_o),   256'd0);
        chk("rst_mdata", mem_data_o,         256'd0);
        @(posedge clk_i); #1;
        rst_i     = 1'b0;
        cpu_req_i = 1'b0;
        model_reset();
        return;
      end
      mem_ack_i  = (c == dly);
      mem_data_i = (c == dly) ? fill : rand_line();
      @(posedge clk_i); #1;
      mem_ack_i  = 1'b0;
      mem_data_i = rand_line();
    end
    valid_m[idx] = 1'b1;
    dirty_m[idx] = 1'b0;
    tag_m[idx]   = tg;
    line_m[idx]  = fill;
    @(negedge clk_i);
    chk("rd_stall", 256'(cpu_stall_o), 256'd1);
    chk("rd_men",   256'(mem_enable_o), 256'd0);
    mem_ack_i = 1'($urandom_range(0, 1));
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("post_stall", 256'(cpu_stall_o), 256'd0);
    chk("post_men",   256'(mem_enable_o), 256'd0);
    if (!we) chk("post_rdata", 256'(cpu_data_o), 256'(line_m[idx][w*32 +: 32]));
    else begin
      line_m[idx][w*32 +: 32] = wdata;
      dirty_m[idx] = 1'b1;
    end
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    rst_i = 1'b1;
    cpu_req_i = 1'b0;
    cpu_we_i = 1'b0;
    cpu_addr_i = '0;
    cpu_data_i = '0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_stall", 256'(cpu_stall_o),  256'd0);
    chk("reset_men",   256'(mem_enable_o), 256'd0);
    chk("reset_mwe",   256'(mem_write_o),  256'd0);
    chk("reset_rdata", 256'(cpu_data_o),   256'd0);
    chk("reset_maddr", 256'(mem_addr_o),   256'd0);
    chk("reset_mdata", mem_data_o,         256'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    access(1'b0, 32'h0000_0400, 32'h0, 0, 1'b0);
    access(1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 0, 1'b0);
    chk("dirty_after_store", 256'(dut.u_sram.dirty_q[0]), 256'd1);
    access(1'b0, 32'h0000_0404, 32'h0, 0, 1'b0);
    chk("reload_store_word", 256'(line_m[0][63:32]), 256'(32'hDEAD_BEEF));
    access(1'b0, 32'h0000_0804, 32'h0, 1, 1'b0);
    chk("wb_mem_word", 256'(mem_m[32'h400][63:32]), 256'(32'hDEAD_BEEF));
    chk("valid_after_refill", 256'(dut.u_sram.valid_q[0]), 256'd1);
    chk("dirty_after_refill", 256'(dut.u_sram.dirty_q[0]), 256'd0);
`ifdef DCACHE_STATS_EN
    chk("hit_cnt_directed",  256'(dut.hit_cnt),  256'd2);
    chk("miss_cnt_directed", 256'(dut.miss_cnt), 256'd2);
`endif

    access(1'b0, 32'h0000_0C20, 32'h0, 10, 1'b0);
    access(1'b1, 32'h0000_1024, 32'h1234_5678, 10, 1'b0);
    access(1'b0, 32'h0000_2020, 32'h0, 10, 1'b0);

    access(1'b0, 32'h0000_0400, 32'h0, 2, 1'b1);
    chk("all_invalid", 256'(dut.u_sram.valid_q), 256'd0);
    idle_cycle();
    access(1'b0, 32'h0000_0400, 32'h0, 0, 1'b0);
    chk_stats();

    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 4) == 0) idle_cycle();
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
      access(1'($urandom_range(0, 1)), a, $urandom(), $urandom_range(0, 3), 1'b0);
    end
    chk_stats();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter LINES, default 32, SHALL set the number of direct-mapped lines (power of two).
REQ-003 Parameter LINE_W, default 256, SHALL set the line and memory-beat width in bits.
REQ-004 Parameter ADDR_W, default 32, SHALL set the byte-address width.
REQ-005 The ports SHALL be as follows.
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cpu_req_i  in  1  MEM-stage load/store request
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  ADDR_W  byte address, word-aligned
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  stall the pipeline (feeds mem_stall)
- mem_data_i  in  LINE_W  refill line
- mem_ack_i  in  1  one-cycle completion pulse
- mem_data_o  out  LINE_W  write-back line
- mem_addr_o  out  ADDR_W  line address, low 5 bits zero
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1 = write-back, 0 = refill

Function
REQ-006 The cache SHALL be direct-mapped, write-back and write-allocate.
- Address split: offset [4:0], index [9:5], tag [31:10].
- Tag entry: 24 bits = {valid, dirty, tag[21:0]}.
REQ-007 A hit SHALL be: cpu_req_i, entry valid, and tag equal.
- On a hit, cpu_stall_o is 0 in the same cycle.
- cpu_data_o is the addressed word combinationally.
- A store updates the word and sets dirty at the next clock edge.
REQ-008 cpu_stall_o SHALL be asserted combinationally in the cycle a miss is detected and SHALL stay high until the post-refill hit cycle.
REQ-009 The FSM states SHALL be IDLE, MISS, WRITEBACK, REFILL and REFILL_DONE.
- IDLE: miss -> MISS.
- MISS: dirty -> WRITEBACK, else -> REFILL.
- WRITEBACK: on mem_ack_i -> REFILL.
- REFILL: on mem_ack_i -> REFILL_DONE.
- REFILL_DONE -> IDLE, where the request re-evaluates as a hit.
REQ-010 In WRITEBACK the block SHALL drive:
- mem_enable_o = 1, mem_write_o = 1
- mem_addr_o = {stored tag, index, 5'b0}
- mem_data_o = stored line
REQ-011 In REFILL the block SHALL drive:
- mem_enable_o = 1, mem_write_o = 0
- mem_addr_o = {request tag, index, 5'b0}
- On ack, it writes mem_data_i into the line with valid = 1 and dirty = 0.
REQ-012 mem_enable_o SHALL hold steady with constant address and data until mem_ack_i, and SHALL be 0 in every other state.
REQ-013 mem_ack_i SHALL be ignored in IDLE, MISS and REFILL_DONE.
REQ-014 CPU inputs SHALL be sampled only in IDLE, because the pipeline is frozen while cpu_stall_o = 1.
REQ-015 cpu_req_i = 0 SHALL force cpu_stall_o = 0 and cause no state change.

Reset
REQ-016 rst_i SHALL, at any point including mid-transfer:
- return the FSM to IDLE;
- clear every valid and dirty bit;
- force mem_enable_o, mem_write_o and cpu_stall_o to 0.
An outstanding transfer is abandoned.
REQ-017 Data array contents SHALL NOT be cleared by reset.
REQ-018 While rst_i is high, the output reset values SHALL be:
- cpu_data_o = 0
- mem_addr_o = 0
- mem_data_o = 0

Configuration
REQ-019 With DCACHE_STATS_EN defined, the block SHALL count hits and misses, each on a 32-bit wrapping counter readable hierarchically as hit_cnt and miss_cnt.
- Hits count in IDLE only, excluding the post-refill hit.
- Misses count on entry to MISS.
- Both counters reset to 0.
REQ-020 Without DCACHE_STATS_EN, the block SHALL contain no counters, and all other behaviour SHALL be identical.

Structure
REQ-021 A shared package SHALL hold:
- the FSM state enum;
- the tag-entry typedef;
- the constants OFFSET_W = 5, INDEX_W = 5, TAG_W = 22.
REQ-022 The tag and data arrays SHALL live in one sub-module, dcache_sram, with one synchronous-write port and a combinational read.

Verification
REQ-023 The bench SHALL cover these directed scenarios.
- Cold load of 0x0000_0400 -> miss: REFILL at mem_addr_o 0x400, stall held until ack+1, then the loaded word is returned and stall drops.
- Store 0xDEADBEEF to 0x404 after that load -> hit with no stall; the line becomes dirty; a reload of 0x404 returns 0xDEADBEEF.
- Load 0x0000_0804 (same index, new tag) -> WRITEBACK to 0x400 with the modified line, then REFILL from 0x800, valid = 1, dirty = 0.
- Memory ack delayed 10 cycles -> mem_enable_o, address and data stay stable for all 10 cycles, and stall stays high.
- rst_i asserted during REFILL -> next cycle IDLE, mem_enable_o = 0, all lines invalid; a reload of 0x400 misses.
- With DCACHE_STATS_EN: the first three scenarios end with hit_cnt = 2 and miss_cnt = 2.
